muldiv_unit: RTL

Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-wide core. Sits beside the single-cycle ALU in the execute stage. Accepts one operation through a valid/ready handshake and returns the result after a fixed multi-cycle latency. Holds the result under back-pressure and supports a pipeline flush.

---
 rtl/muldiv_unit_pkg.sv | 44 ++++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared execute-stage definitions: multiply/divide op encoding and decoded control bundle.
// The muldiv_op_type values equal the instruction funct3 field.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_type;

  localparam logic [6:0] MULDIV_OPCODE_FUNCT7 = 7'b0000001;

  typedef struct packed {
    logic          is_alu;
    logic          is_branch;
    logic          is_load;
    logic          is_store;
    logic          is_muldiv;
    muldiv_op_type muldiv_op;
  } control_type;

  function automatic logic is_div_op(input muldiv_op_type op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem_op(input muldiv_op_type op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  // rs1 is treated as signed for these ops; rs2 only for MULH/DIV/REM.
  function automatic logic a_is_signed(input muldiv_op_type op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic b_is_signed(input muldiv_op_type op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit with valid/ready handshake.
// Multiply and divide share one 2*XLEN shift register and one step counter.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  muldiv_op_type   in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e            state;
  muldiv_op_type     op;
  logic [CNT_W-1:0]  cnt;
  logic              fin;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic              neg_res;
  logic              neg_rem;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   sign_a;
  logic                   sign_b;
  logic [XLEN-1:0]        mag_a;
  logic [XLEN-1:0]        mag_b;
  logic                   div_by_zero;
  logic                   div_ovf;

  assign a_s    = in_a;
  assign b_s    = in_b;
  assign sign_a = a_is_signed(in_op) && (a_s < 0);
  assign sign_b = b_is_signed(in_op) && (b_s < 0);
  assign mag_a  = neg_w(in_a, sign_a);
  assign mag_b  = neg_w(in_b, sign_b);

  assign div_by_zero = is_div_op(in_op) && (in_b == '0);
  assign div_ovf     = (in_op == MD_DIV || in_op == MD_REM)
                       && (in_a == {1'b1, {(XLEN-1){1'b0}}})
                       && (in_b == {XLEN{1'b1}});

  // Multiply step: conditional add into the upper half, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                    + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide step: remainder in the upper half, dividend/quotient in the lower.
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic              unused_bits;

  assign div_shift   = acc[2*XLEN-1:XLEN-1];
  assign div_diff    = {1'b0, div_shift} - {2'b00, opb};
  assign div_next    = div_diff[XLEN+1]
                       ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                       : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
  assign unused_bits = div_diff[XLEN];

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   result;

  always_comb begin
    prod   = neg_dw(acc, neg_res);
    quot   = neg_w(acc[XLEN-1:0], neg_res);
    rem    = neg_w(acc[2*XLEN-1:XLEN], neg_rem);
    result = '0;
    unique case (op)
      MD_MUL:                       result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quot;
      MD_REM, MD_REMU:              result = rem;
      default:                      result = '0;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      op         <= MD_MUL;
      cnt        <= '0;
      fin        <= 1'b0;
      acc        <= '0;
      opb        <= '0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      out_result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            op      <= in_op;
            opb     <= mag_b;
            acc     <= {{XLEN{1'b0}}, mag_a};
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            cnt     <= CNT_W'(XLEN - 1);
            fin     <= 1'b0;
            if (div_by_zero) begin
              out_result <= is_rem_op(in_op) ? in_a : {XLEN{1'b1}};
              state      <= S_DONE;
            end else if (div_ovf) begin
              out_result <= is_rem_op(in_op) ? {XLEN{1'b0}} : in_a;
              state      <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (fin) begin
            out_result <= result;
            state      <= S_DONE;
          end else begin
            acc <= is_div_op(op) ? div_next : mul_next;
            if (cnt == '0) fin <= 1'b1;
            else           cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (flush || out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
